// File: rtl/word_serializer.sv
// Word serializer: one parallel word per handshake, shifted out as start, LSB-first data, stop.
// Define SER_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module word_serializer #(
    parameter int DATA_W       = 32,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int              BIT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int              BAUD_W    = 16;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SER_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;
    logic                tick;
`ifdef SER_PARITY_EN
    logic                parity_q, parity_d;
`endif

    assign tick = (baud_q == BAUD_LAST);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        shreg_d = shreg_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
`ifdef SER_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != IDLE) begin
            baud_d = tick ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (data_valid) begin
                    state_d = START;
                    shreg_d = data_in;
                    bit_d   = '0;
                    baud_d  = '0;
                    tx_d    = 1'b0;
`ifdef SER_PARITY_EN
                    parity_d = ^data_in;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                end
            end
            DATA: begin
                // tx_d is the value for the *next* bit period, so it looks one shift ahead.
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef SER_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shreg_d[0];
                    end
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef SER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx_out     = tx_q;
    assign frame_done = done_q;
    assign busy       = (state_q != IDLE);
    assign data_ready = (state_q == IDLE);

endmodule
